// File: rtl/lzma_pkg.sv
// lzma_pkg: shared LZMA header constants, header byte lookup and packer state encoding.
package lzma_pkg;
  localparam int LZMA_HDR_LEN = 13;
  localparam logic [7:0] LZMA_PROPS_BYTE = 8'h5E;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [31:0] dict);
    logic [7:0] b;
    b = 8'hFF;
    if (idx == 4'd0) b = LZMA_PROPS_BYTE;
    else if (idx <= 4'd4) b = dict[{idx[1:0] - 2'd1, 3'b000} +: 8];
    return b;
  endfunction
endpackage

// File: rtl/lzma_pack_fifo.sv
// lzma_pack_fifo: show-ahead synchronous FIFO; writes have no ready and report a drop when full.
module lzma_pack_fifo #(
  parameter int DW = 9,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          drop
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign drop = wr_en && full;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en && !full) wp <= wp + (AW+1)'(1);
      if (rd_en && !empty) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/lzma_header_packer.sv
// lzma_header_packer: prepends the 13-byte LZMA header to each buffered payload stream.
// Defining LZMA_PACKER_BYTECNT_EN adds o_bytecnt, the payload bytes sent in the current file.
module lzma_header_packer
  import lzma_pkg::*;
#(
  parameter int          FIFO_AW   = 10,
  parameter logic [31:0] DICT_SIZE = 32'h00020000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  input  logic        o_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_overflow
`ifdef LZMA_PACKER_BYTECNT_EN
  ,
  output logic [31:0] o_bytecnt
`endif
);
  state_t state, state_nx;
  logic [3:0] idx, idx_nx;
  logic [8:0] head;
  logic full, empty, drop, xfer, pop, hdr_done;
  lzma_pack_fifo #(.DW(9), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .wr_en(i_valid),
    .wr_data({i_last, i_data}),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .drop(drop)
  );
  assign xfer = o_valid && o_ready;
  assign pop = xfer && state == BODY;
  assign hdr_done = idx == 4'(LZMA_HDR_LEN - 1);
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      idx <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      o_overflow <= o_overflow | drop;
    end
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    o_valid = 1'b0;
    o_data = '0;
    o_last = 1'b0;
    case (state)
      IDLE: begin
        idx_nx = '0;
        state_nx = empty ? IDLE : HDR;
      end
      HDR: begin
        o_valid = 1'b1;
        o_data = hdr_byte(idx, DICT_SIZE);
        idx_nx = !o_ready ? idx : hdr_done ? '0 : idx + 4'd1;
        state_nx = o_ready && hdr_done ? BODY : HDR;
      end
      BODY: begin
        // show-ahead head is only presented while it holds a real entry
        o_valid = !empty;
        o_data = empty ? '0 : head[7:0];
        o_last = !empty && head[8];
        state_nx = xfer && head[8] ? IDLE : BODY;
      end
      default: state_nx = IDLE;
    endcase
  end
`ifdef LZMA_PACKER_BYTECNT_EN
  always_ff @(posedge clk)
    if (!rstn) o_bytecnt <= '0;
    else if (xfer && state == HDR && idx == '0) o_bytecnt <= '0;
    else if (pop) o_bytecnt <= o_bytecnt + 32'd1;
`endif
endmodule

// File: tb/tb_lzma_header_packer.sv
// tb_lzma_header_packer: scoreboard bench with randomized streams against a file-level reference model.
module tb_lzma_header_packer;
  localparam logic [31:0] DICT = 32'h00800000;
  logic clk = 1'b0, rstn = 1'b0, i_valid = 1'b0, i_last = 1'b0, o_ready = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic o_valid, o_last, o_overflow;
  logic [7:0] o_data;
`ifdef LZMA_PACKER_BYTECNT_EN
  logic [31:0] o_bytecnt;
  int exp_bc = 0;
`endif
  lzma_header_packer #(.FIFO_AW(2), .DICT_SIZE(DICT)) dut (
    .clk(clk),
    .rstn(rstn),
    .i_valid(i_valid),
    .i_data(i_data),
    .i_last(i_last),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_last(o_last),
    .o_overflow(o_overflow)
`ifdef LZMA_PACKER_BYTECNT_EN
    ,
    .o_bytecnt(o_bytecnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [7:0] d; logic l; logic p; logic f;} exp_t;
  exp_t q[$];
  logic [7:0] hdr [13] = '{8'h5E, 8'h00, 8'h00, 8'h80, 8'h00,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int checks = 0, passes = 0, written = 0, popped = 0, xfers = 0, x0;
  bit new_stream = 1'b1, rand_rdy = 1'b0, tog_rdy = 1'b0, have_prev = 1'b0;
  logic [8:0] prev;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic fail(input string n);
    checks++;
    $display("FAIL %s: bound expired", n);
  endtask

  // one file on the wire is the fixed header followed by the stream's payload bytes
  task automatic push_header();
    for (int i = 0; i < 13; i++) q.push_back('{d: hdr[i], l: 1'b0, p: 1'b0, f: (i == 0)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) have_prev = 1'b0;
    else begin
      if (have_prev) chk("stable", 32'({o_valid, o_last, o_data}), 32'({1'b1, prev}));
`ifdef LZMA_PACKER_BYTECNT_EN
      chk("bytecnt", o_bytecnt, 32'(exp_bc));
`endif
      if (o_valid && o_ready) begin
        if (q.size() == 0) fail("unexpected_byte");
        else begin
          e = q.pop_front();
          chk("byte", 32'({o_last, o_data}), 32'({e.l, e.d}));
          if (e.p) popped++;
`ifdef LZMA_PACKER_BYTECNT_EN
          if (e.f) exp_bc = 0;
          else if (e.p) exp_bc++;
`endif
        end
        xfers++;
      end
      have_prev = o_valid && !o_ready;
      prev = {o_last, o_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) o_ready = 1'($urandom_range(0, 1));
    else if (tog_rdy) o_ready = ~o_ready;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    while (written - popped >= 4 && t < 1000) begin
      step();
      t++;
    end
    if (t == 1000) fail("fifo_space_timeout");
    if (new_stream) push_header();
    q.push_back('{d: d, l: l, p: 1'b1, f: 1'b0});
    new_stream = l;
    written++;
    i_valid = 1'b1;
    i_data = d;
    i_last = l;
    step();
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic drain(input int lim);
    int t = 0;
    while (q.size() != 0 && t < lim) begin
      step();
      t++;
    end
    if (q.size() != 0) fail("drain_timeout");
    repeat (3) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_valid = 1'b0;
    step();
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_o_last", 32'(o_last), 0);
    chk("rst_o_overflow", 32'(o_overflow), 0);
    step();
    q.delete();
    written = 0;
    popped = 0;
    new_stream = 1'b1;
`ifdef LZMA_PACKER_BYTECNT_EN
    exp_bc = 0;
`endif
    rstn = 1'b1;
  endtask

  initial begin
    int t, len;
    do_reset();
    o_ready = 1'b1;
    x0 = xfers;
    send(8'h5D, 1'b0);
    chk("latency_idle", 32'(o_valid), 0);
    send(8'h00, 1'b0);
    chk("latency_hdr_valid", 32'({o_valid, o_data}), 32'({1'b1, 8'h5E}));
    send(8'h41, 1'b1);
    repeat (12) step();
    chk("latency_first_payload", 32'({o_valid, o_last, o_data}), 32'({1'b1, 1'b0, 8'h5D}));
    drain(200);
    chk("basic_xfers", 32'(xfers - x0), 16);

    o_ready = 1'b0;
    x0 = xfers;
    send(8'h5D, 1'b0);
    send(8'h00, 1'b0);
    send(8'h41, 1'b1);
    o_ready = 1'b1;
    tog_rdy = 1'b1;
    drain(200);
    tog_rdy = 1'b0;
    o_ready = 1'b1;
    chk("backpressure_xfers", 32'(xfers - x0), 16);

    x0 = xfers;
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    drain(300);
    chk("back_to_back_xfers", 32'(xfers - x0), 29);

    do_reset();
    o_ready = 1'b0;
    push_header();
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      i_data = 8'(8'hA0 + i);
      i_last = (i == 3);
      if (i < 4) q.push_back('{d: i_data, l: i_last, p: 1'b1, f: 1'b0});
      step();
      chk("overflow_flag", 32'(o_overflow), 32'(i >= 4));
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    written = 4;
    o_ready = 1'b1;
    drain(200);
    chk("overflow_sticky", 32'(o_overflow), 1);
    do_reset();

    o_ready = 1'b0;
    x0 = xfers;
    send(8'hCC, 1'b1);
    t = 0;
    while (!o_valid && t < 20) begin
      step();
      t++;
    end
    if (!o_valid) fail("hdr_start_timeout");
    o_ready = 1'b1;
    repeat (5) step();
    o_ready = 1'b0;
    chk("mid_hdr_xfers", 32'(xfers - x0), 5);
    do_reset();
    o_ready = 1'b1;
    x0 = xfers;
    send(8'hAB, 1'b1);
    drain(200);
    chk("after_reset_xfers", 32'(xfers - x0), 14);

    rand_rdy = 1'b1;
    for (int s = 0; s < 20; s++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) send(8'($urandom), b == len - 1);
      repeat ($urandom_range(0, 3)) step();
    end
    drain(5000);
    rand_rdy = 1'b0;
    chk("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
